// File: rtl/module_corrector_hamming_pkg.sv
// ============================================================================
// Module   : paquete_hamming
// Purpose  : Shared types, constants and helpers for the SECDED corrector.
// Revision : 1.0
// ============================================================================
`default_nettype none

package paquete_hamming;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        CORRIGE  = 2'd1,
        PRESENTA = 2'd2
    } estado_corrector_t;

    localparam logic [3:0] POS_PARIDAD_GLOBAL = 4'd8;

    // Word layout [p0,i3,i2,i1,c2,i0,c1,c0]
    localparam int BIT_DATO_I0        = 2;
    localparam int BIT_DATO_I1        = 4;
    localparam int BIT_DATO_I2        = 5;
    localparam int BIT_DATO_I3        = 6;
    localparam int BIT_PARIDAD_GLOBAL = 7;

    function automatic logic [3:0] extraer_datos(input logic [7:0] w);
        return {w[BIT_DATO_I3], w[BIT_DATO_I2], w[BIT_DATO_I1], w[BIT_DATO_I0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/module_corrector_hamming_if.sv
// ============================================================================
// Module   : module_corrector_hamming_if
// Purpose  : Input/output handshake bundle between detector, corrector and sink.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface module_corrector_hamming_if;

    logic       entrada_valida;
    logic       entrada_lista;
    logic [7:0] datos_recibidos;
    logic [2:0] sindrome;
    logic       bit_error;
    logic       error_doble;
    logic       salida_valida;
    logic       salida_lista;
    logic [7:0] palabra_corregida;
    logic [3:0] dato_corregido;
    logic [3:0] posicion_error;
    logic       error_simple_out;
    logic       error_doble_out;

    modport master (
        output entrada_valida, datos_recibidos, sindrome, bit_error, error_doble,
        output salida_lista,
        input  entrada_lista, salida_valida, palabra_corregida, dato_corregido,
        input  posicion_error, error_simple_out, error_doble_out
    );

    modport slave (
        input  entrada_valida, datos_recibidos, sindrome, bit_error, error_doble,
        input  salida_lista,
        output entrada_lista, salida_valida, palabra_corregida, dato_corregido,
        output posicion_error, error_simple_out, error_doble_out
    );

endinterface

`default_nettype wire

// File: rtl/module_corrector_hamming_contador.sv
// ============================================================================
// Module   : module_contador_saturado
// Purpose  : Saturating up-counter with synchronous clear taking priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

module module_contador_saturado #(
    parameter int ANCHO = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             limpiar,
    input  wire logic             incrementa,
    output logic      [ANCHO-1:0] cuenta
);

    localparam logic [ANCHO-1:0] C_UNO    = {{(ANCHO-1){1'b0}}, 1'b1};
    localparam logic [ANCHO-1:0] C_MAXIMO = {ANCHO{1'b1}};

    logic [ANCHO-1:0] cuenta_q;
    logic [ANCHO-1:0] cuenta_d;

    always_comb begin
        cuenta_d = cuenta_q;
        if (limpiar) begin
            cuenta_d = '0;
        end else if (incrementa && (cuenta_q != C_MAXIMO)) begin
            cuenta_d = cuenta_q + C_UNO;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign cuenta = cuenta_q;

endmodule

`default_nettype wire

// File: rtl/module_corrector_hamming.sv
// ============================================================================
// Module   : module_corrector_hamming
// Purpose  : Registered SECDED single-error corrector with payload extraction.
// Revision : 1.0
// ============================================================================
`default_nettype none

module module_corrector_hamming
    import paquete_hamming::*;
#(
    parameter int ANCHO_CONTADOR = 8
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    module_corrector_hamming_if.slave      bus,
    input  wire logic                      limpiar_contadores,
    output logic      [ANCHO_CONTADOR-1:0] cuenta_simples,
    output logic      [ANCHO_CONTADOR-1:0] cuenta_dobles
);

    estado_corrector_t estado_q, estado_d;

    logic [7:0] captura_q,   captura_d;
    logic [2:0] sindrome_q,  sindrome_d;
    logic       bit_err_q,   bit_err_d;
    logic       doble_in_q,  doble_in_d;

    logic [7:0] palabra_q,   palabra_d;
    logic [3:0] dato_q,      dato_d;
    logic [3:0] posicion_q,  posicion_d;
    logic       simple_q,    simple_d;
    logic       doble_q,     doble_d;

    logic       w_es_simple;
    logic       w_es_doble;
    logic [7:0] w_palabra_fija;
    logic [3:0] w_posicion_fija;

    // A double error wins over the general flag; a single error needs bit_error alone.
    assign w_es_doble  = doble_in_q;
    assign w_es_simple = bit_err_q & ~doble_in_q;

    always_comb begin
        w_palabra_fija  = captura_q;
        w_posicion_fija = 4'd0;
        if (w_es_simple) begin
            if (sindrome_q != 3'd0) begin
                w_palabra_fija  = captura_q ^ (8'd1 << (sindrome_q - 3'd1));
                w_posicion_fija = {1'b0, sindrome_q};
            end else begin
                w_palabra_fija  = captura_q ^ (8'd1 << BIT_PARIDAD_GLOBAL);
                w_posicion_fija = POS_PARIDAD_GLOBAL;
            end
        end
    end

    always_comb begin
        estado_d   = estado_q;
        captura_d  = captura_q;
        sindrome_d = sindrome_q;
        bit_err_d  = bit_err_q;
        doble_in_d = doble_in_q;
        palabra_d  = palabra_q;
        dato_d     = dato_q;
        posicion_d = posicion_q;
        simple_d   = simple_q;
        doble_d    = doble_q;
        case (estado_q)
            REPOSO: begin
                if (bus.entrada_valida) begin
                    captura_d  = bus.datos_recibidos;
                    sindrome_d = bus.sindrome;
                    bit_err_d  = bus.bit_error;
                    doble_in_d = bus.error_doble;
                    estado_d   = CORRIGE;
                end
            end
            CORRIGE: begin
                palabra_d  = w_palabra_fija;
                dato_d     = extraer_datos(w_palabra_fija);
                posicion_d = w_posicion_fija;
                simple_d   = w_es_simple;
                doble_d    = w_es_doble;
                estado_d   = PRESENTA;
            end
            PRESENTA: begin
                if (bus.salida_lista) begin
                    estado_d = REPOSO;
                end
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q   <= REPOSO;
            captura_q  <= '0;
            sindrome_q <= '0;
            bit_err_q  <= 1'b0;
            doble_in_q <= 1'b0;
            palabra_q  <= '0;
            dato_q     <= '0;
            posicion_q <= '0;
            simple_q   <= 1'b0;
            doble_q    <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            captura_q  <= captura_d;
            sindrome_q <= sindrome_d;
            bit_err_q  <= bit_err_d;
            doble_in_q <= doble_in_d;
            palabra_q  <= palabra_d;
            dato_q     <= dato_d;
            posicion_q <= posicion_d;
            simple_q   <= simple_d;
            doble_q    <= doble_d;
        end
    end

    assign bus.entrada_lista     = (estado_q == REPOSO);
    assign bus.salida_valida     = (estado_q == PRESENTA);
    assign bus.palabra_corregida = palabra_q;
    assign bus.dato_corregido    = dato_q;
    assign bus.posicion_error    = posicion_q;
    assign bus.error_simple_out  = simple_q;
    assign bus.error_doble_out   = doble_q;

    module_contador_saturado #(
        .ANCHO (ANCHO_CONTADOR)
    ) u_contador_simples (
        .clk        (clk),
        .rst        (rst),
        .limpiar    (limpiar_contadores),
        .incrementa ((estado_q == CORRIGE) && w_es_simple),
        .cuenta     (cuenta_simples)
    );

    module_contador_saturado #(
        .ANCHO (ANCHO_CONTADOR)
    ) u_contador_dobles (
        .clk        (clk),
        .rst        (rst),
        .limpiar    (limpiar_contadores),
        .incrementa ((estado_q == CORRIGE) && w_es_doble),
        .cuenta     (cuenta_dobles)
    );

endmodule

`default_nettype wire

// File: tb/tb_module_corrector_hamming.sv
// ============================================================================
// Module   : tb_module_corrector_hamming
// Purpose  : Self-checking bench for the SECDED corrector against a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_module_corrector_hamming;

    localparam int ANCHO = 2;
    localparam int MAXC  = (1 << ANCHO) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             limpiar;
    logic [ANCHO-1:0] cuenta_simples;
    logic [ANCHO-1:0] cuenta_dobles;

    int n_checks = 0;
    int n_errors = 0;
    int m_simples = 0;
    int m_dobles  = 0;

    module_corrector_hamming_if bus ();

    module_corrector_hamming #(
        .ANCHO_CONTADOR (ANCHO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .bus                (bus),
        .limpiar_contadores (limpiar),
        .cuenta_simples     (cuenta_simples),
        .cuenta_dobles      (cuenta_dobles)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference rules: what the corrected word, position and payload must be.
    function automatic logic [7:0] ref_word(input logic [7:0] w, input int s, input bit be, input bit ed);
        if (be && !ed) begin
            if (s != 0) return w ^ 8'(1 << (s - 1));
            return w ^ 8'h80;
        end
        return w;
    endfunction

    function automatic int ref_pos(input int s, input bit be, input bit ed);
        if (be && !ed) return (s != 0) ? s : 8;
        return 0;
    endfunction

    function automatic int ref_payload(input logic [7:0] w);
        int v;
        v = ((w >> 6) & 1) * 8 + ((w >> 5) & 1) * 4 + ((w >> 4) & 1) * 2 + ((w >> 2) & 1);
        return v;
    endfunction

    task automatic check_outputs(input string tag, input logic [7:0] w, input int s, input bit be, input bit ed);
        check_val({tag, "_palabra"}, bus.palabra_corregida, ref_word(w, s, be, ed));
        check_val({tag, "_dato"},    bus.dato_corregido,    ref_payload(ref_word(w, s, be, ed)));
        check_val({tag, "_pos"},     bus.posicion_error,    ref_pos(s, be, ed));
        check_val({tag, "_simple"},  bus.error_simple_out,  (be && !ed) ? 1 : 0);
        check_val({tag, "_doble"},   bus.error_doble_out,   ed ? 1 : 0);
        check_val({tag, "_csimp"},   cuenta_simples,        m_simples);
        check_val({tag, "_cdobl"},   cuenta_dobles,         m_dobles);
    endtask

    task automatic run_word(input string tag, input logic [7:0] w, input int s, input bit be,
                            input bit ed, input int stall, input bit pulso);
        @(negedge clk);
        check_val({tag, "_lista_reposo"}, bus.entrada_lista, 1);
        bus.entrada_valida  = 1'b1;
        bus.datos_recibidos = w;
        bus.sindrome        = 3'(s);
        bus.bit_error       = be;
        bus.error_doble     = ed;
        bus.salida_lista    = 1'b0;
        @(posedge clk);
        #1;
        bus.entrada_valida  = 1'b0;
        bus.datos_recibidos = 8'($urandom);
        bus.sindrome        = 3'($urandom);
        check_val({tag, "_valida_corrige"}, bus.salida_valida, 0);
        check_val({tag, "_lista_corrige"},  bus.entrada_lista, 0);
        if (be && !ed && m_simples < MAXC) m_simples++;
        if (ed && m_dobles < MAXC) m_dobles++;
        @(posedge clk);
        #1;
        check_val({tag, "_valida"}, bus.salida_valida, 1);
        check_outputs(tag, w, s, be, ed);
        for (int i = 0; i < stall; i++) begin
            if (pulso && i == 2) begin
                bus.entrada_valida  = 1'b1;
                bus.datos_recibidos = ~w;
            end else begin
                bus.entrada_valida  = 1'b0;
            end
            @(posedge clk);
            #1;
            check_val({tag, "_hold_valida"}, bus.salida_valida, 1);
            check_val({tag, "_hold_lista"},  bus.entrada_lista, 0);
            check_val({tag, "_hold_palabra"}, bus.palabra_corregida, ref_word(w, s, be, ed));
            check_val({tag, "_hold_pos"},    bus.posicion_error, ref_pos(s, be, ed));
        end
        bus.entrada_valida = 1'b0;
        @(negedge clk);
        bus.salida_lista = 1'b1;
        @(posedge clk);
        #1;
        bus.salida_lista = 1'b0;
        check_val({tag, "_valida_post"}, bus.salida_valida, 0);
        check_val({tag, "_lista_post"},  bus.entrada_lista, 1);
        check_val({tag, "_retiene"},     bus.palabra_corregida, ref_word(w, s, be, ed));
        if (pulso) begin
            @(posedge clk);
            #1;
            check_val({tag, "_pulso_ignorado"}, bus.entrada_lista, 1);
        end
    endtask

    initial begin
        logic [7:0] w;
        int         s;
        bit         be;
        bit         ed;

        rst                 = 1'b1;
        limpiar             = 1'b0;
        bus.entrada_valida  = 1'b0;
        bus.datos_recibidos = 8'h00;
        bus.sindrome        = 3'd0;
        bus.bit_error       = 1'b0;
        bus.error_doble     = 1'b0;
        bus.salida_lista    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_lista",   bus.entrada_lista, 1);
        check_val("rst_valida",  bus.salida_valida, 0);
        check_outputs("rst", 8'h00, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        run_word("limpia",  8'h55, 0, 1'b0, 1'b0, 0, 1'b0);
        run_word("simple5", 8'h45, 5, 1'b1, 1'b0, 0, 1'b0);
        run_word("paridad", 8'hD5, 0, 1'b1, 1'b0, 0, 1'b0);
        run_word("doble",   8'h56, 3, 1'b1, 1'b1, 0, 1'b0);
        run_word("bpress",  8'h45, 5, 1'b1, 1'b0, 5, 1'b1);

        for (int k = 0; k < 40; k++) begin
            w  = 8'($urandom);
            be = 1'($urandom_range(0, 1));
            ed = be ? 1'($urandom_range(0, 1)) : 1'b0;
            s  = be ? int'($urandom_range(0, 7)) : 0;
            run_word("rnd", w, s, be, ed, int'($urandom_range(0, 3)), 1'b0);
        end

        for (int k = 0; k < 5; k++) begin
            run_word("sat", 8'($urandom), int'($urandom_range(1, 7)), 1'b1, 1'b0, 0, 1'b0);
        end
        check_val("sat_simples", cuenta_simples, MAXC);

        // Clear raised during the CORRIGE cycle of a single-error word.
        @(negedge clk);
        bus.entrada_valida  = 1'b1;
        bus.datos_recibidos = 8'h45;
        bus.sindrome        = 3'd5;
        bus.bit_error       = 1'b1;
        bus.error_doble     = 1'b0;
        @(posedge clk);
        #1;
        bus.entrada_valida = 1'b0;
        limpiar            = 1'b1;
        @(posedge clk);
        #1;
        limpiar   = 1'b0;
        m_simples = 0;
        m_dobles  = 0;
        check_val("clr_valida",  bus.salida_valida, 1);
        check_val("clr_simples", cuenta_simples, 0);
        check_val("clr_dobles",  cuenta_dobles, 0);
        check_val("clr_pos",     bus.posicion_error, 5);
        @(negedge clk);
        bus.salida_lista = 1'b1;
        @(posedge clk);
        #1;
        bus.salida_lista = 1'b0;

        run_word("pre_rst", 8'h56, 3, 1'b1, 1'b1, 0, 1'b0);

        // Reset raised during the CORRIGE cycle discards the captured word.
        @(negedge clk);
        bus.entrada_valida  = 1'b1;
        bus.datos_recibidos = 8'h45;
        bus.sindrome        = 3'd5;
        bus.bit_error       = 1'b1;
        bus.error_doble     = 1'b0;
        @(posedge clk);
        #1;
        bus.entrada_valida = 1'b0;
        rst                = 1'b1;
        #1;
        m_simples = 0;
        m_dobles  = 0;
        check_val("rstmid_valida", bus.salida_valida, 0);
        check_val("rstmid_lista",  bus.entrada_lista, 1);
        check_outputs("rstmid", 8'h00, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_val("rstmid_hold_valida", bus.salida_valida, 0);
        check_val("rstmid_hold_csimp",  cuenta_simples, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("rstmid_after_valida", bus.salida_valida, 0);
        check_val("rstmid_after_lista",  bus.entrada_lista, 1);

        run_word("final", 8'hD5, 0, 1'b1, 1'b0, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
